// File: rtl/bus_transaction_unit_pkg.sv
// Shared transaction-control encoding plus bus-stage state type and
// the per-command byte-enable lookup.
package transactionGroup;

    typedef logic [3:0] controlBus;

    localparam controlBus NO_OP       = 4'd0;
    localparam controlBus READ        = 4'd1;
    localparam controlBus WRITE_BYTE0 = 4'd2;
    localparam controlBus WRITE_BYTE1 = 4'd3;
    localparam controlBus WRITE_BYTE2 = 4'd4;
    localparam controlBus WRITE_BYTE3 = 4'd5;
    localparam controlBus WRITE_WORD0 = 4'd6;
    localparam controlBus WRITE_WORD1 = 4'd7;
    localparam controlBus WRITE_DWORD = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2
    } busStates;

    // All-zero result doubles as "not a command" (NO_OP or unused encoding).
    function automatic logic [3:0] cmd_byte_enable(input controlBus cmd);
        case (cmd)
            READ, WRITE_DWORD: cmd_byte_enable = 4'b1111;
            WRITE_BYTE0:       cmd_byte_enable = 4'b0001;
            WRITE_BYTE1:       cmd_byte_enable = 4'b0010;
            WRITE_BYTE2:       cmd_byte_enable = 4'b0100;
            WRITE_BYTE3:       cmd_byte_enable = 4'b1000;
            WRITE_WORD0:       cmd_byte_enable = 4'b0011;
            WRITE_WORD1:       cmd_byte_enable = 4'b1100;
            default:           cmd_byte_enable = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/bus_transaction_unit_lane_steer.sv
// Combinational mapping of a command and right-justified store data onto
// byte enables, replicated write lanes and the write flag.
module bus_lane_steer
    import transactionGroup::*;
(
    input  controlBus   cmd,
    input  logic [31:0] write_data,
    output logic [3:0]  byte_enable,
    output logic [31:0] steered_data,
    output logic        is_write
);

    always_comb begin
        byte_enable  = cmd_byte_enable(cmd);
        steered_data = 32'h0;
        is_write     = 1'b0;
        case (cmd)
            WRITE_BYTE0, WRITE_BYTE1, WRITE_BYTE2, WRITE_BYTE3: begin
                steered_data = {4{write_data[7:0]}};
                is_write     = 1'b1;
            end
            WRITE_WORD0, WRITE_WORD1: begin
                steered_data = {2{write_data[15:0]}};
                is_write     = 1'b1;
            end
            WRITE_DWORD: begin
                steered_data = write_data;
                is_write     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_transaction_unit.sv
// Single-outstanding request/ack bus master stage: latches one command,
// holds the request until ack or timeout, and stalls the controller meanwhile.
module bus_transaction_unit
    import transactionGroup::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  controlBus             transactionControl,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    output logic                  stall,
    output logic [31:0]           readData,
    output logic                  readValid,
    output logic                  busError,
    output logic [ADDR_WIDTH-1:0] busAddress,
    output logic [31:0]           busWriteData,
    output logic [3:0]            busByteEnable,
    output logic                  busRequest,
    output logic                  busWrite,
    input  logic                  busAck,
    input  logic [31:0]           busReadData
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

    busStates              state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic [3:0]  steer_be;
    logic [31:0] steer_data;
    logic        steer_wr;

    bus_lane_steer u_lane_steer (
        .cmd          (transactionControl),
        .write_data   (writeData),
        .byte_enable  (steer_be),
        .steered_data (steer_data),
        .is_write     (steer_wr)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                // Unused encodings have no enables, so they fall through as NO_OP.
                if (steer_be != 4'b0000) begin
                    addr_d  = address & ADDR_MASK;
                    be_d    = steer_be;
                    wdata_d = steer_data;
                    wr_d    = steer_wr;
                    cnt_d   = 16'd0;
                    state_d = ACTIVE;
                    stall   = 1'b1;
                end
            end
            ACTIVE: begin
                if (busAck) begin
                    state_d = IDLE;
                    if (!wr_q) begin
                        rdata_d  = busReadData;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                    if (cnt_q == CNT_LAST) state_d = ERROR;
                    else                   cnt_d   = cnt_q + 16'd1;
                end
            end
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign busRequest    = (state_q == ACTIVE);
    assign busWrite      = (state_q == ACTIVE) && wr_q;
    assign busByteEnable = (state_q == ACTIVE) ? be_q : 4'b0000;
    assign busAddress    = addr_q;
    assign busWriteData  = wdata_q;
    assign busError      = (state_q == ERROR);
    assign readData      = rdata_q;
    assign readValid     = rvalid_q;

endmodule

// File: tb/tb_bus_transaction_unit.sv
// Directed self-checking bench for bus_transaction_unit (timeout set to 4).
module tb_bus_transaction_unit;
    import transactionGroup::*;

    logic        clk = 1'b0;
    logic        reset;
    controlBus   transactionControl;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        stall;
    logic [31:0] readData;
    logic        readValid;
    logic        busError;
    logic [31:0] busAddress;
    logic [31:0] busWriteData;
    logic [3:0]  busByteEnable;
    logic        busRequest;
    logic        busWrite;
    logic        busAck;
    logic [31:0] busReadData;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_transaction_unit #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .transactionControl (transactionControl),
        .address            (address),
        .writeData          (writeData),
        .stall              (stall),
        .readData           (readData),
        .readValid          (readValid),
        .busError           (busError),
        .busAddress         (busAddress),
        .busWriteData       (busWriteData),
        .busByteEnable      (busByteEnable),
        .busRequest         (busRequest),
        .busWrite           (busWrite),
        .busAck             (busAck),
        .busReadData        (busReadData)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; transactionControl = NO_OP; address = '0; writeData = '0;
        busAck = 1'b0; busReadData = '0;
        tick(); tick();
        n_checks++;
        if ({busRequest, busWrite, busByteEnable, busError, readValid, stall} !== 9'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got req=%0b wr=%0b be=%b err=%0b rv=%0b stall=%0b want all 0",
                busRequest, busWrite, busByteEnable, busError, readValid, stall);
        end
        n_checks++;
        if ({readData, busAddress, busWriteData} !== 96'b0) begin
            n_fail++; $display("FAIL reset_data: got rd=%h addr=%h wd=%h want 0", readData, busAddress, busWriteData);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read();
        int stall_cnt = 0;
        transactionControl = READ; address = 32'h1003; #1;
        if (stall === 1'b1) stall_cnt++;
        n_checks++;
        if (busRequest !== 1'b0) begin n_fail++; $display("FAIL rd_issue_req: got %0b want 0", busRequest); end
        tick();
        n_checks++;
        if (busRequest !== 1'b1 || busAddress !== 32'h1000 || busByteEnable !== 4'b1111 || busWrite !== 1'b0) begin
            n_fail++; $display("FAIL rd_bus: got req=%0b addr=%h be=%b wr=%0b want 1 00001000 1111 0",
                busRequest, busAddress, busByteEnable, busWrite);
        end
        for (int i = 0; i < 3; i++) begin
            if (stall === 1'b1) stall_cnt++;
            tick();
        end
        busAck = 1'b1; busReadData = 32'hDEADBEEF; #1;
        if (stall === 1'b1) stall_cnt++;
        n_checks++;
        if (busRequest !== 1'b1) begin n_fail++; $display("FAIL rd_ack_req: got %0b want 1", busRequest); end
        n_checks++;
        if (stall_cnt != 4) begin n_fail++; $display("FAIL rd_stall_cycles: got %0d want 4", stall_cnt); end
        tick();
        busAck = 1'b0; transactionControl = NO_OP; #1;
        n_checks++;
        if (readValid !== 1'b1 || readData !== 32'hDEADBEEF || busRequest !== 1'b0) begin
            n_fail++; $display("FAIL rd_capture: got rv=%0b rd=%h req=%0b want 1 deadbeef 0", readValid, readData, busRequest);
        end
        tick();
        n_checks++;
        if (readValid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_pulse: got %0b want 0", readValid); end
    endtask

    task automatic test_write_byte();
        transactionControl = WRITE_BYTE2; writeData = 32'h000000A5; address = 32'h22; #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL wb_issue_stall: got %0b want 1", stall); end
        tick();
        busAck = 1'b1; #1;
        n_checks++;
        if (busWriteData !== 32'hA5A5A5A5 || busByteEnable !== 4'b0100 || busWrite !== 1'b1
            || busRequest !== 1'b1 || stall !== 1'b0 || busAddress !== 32'h20) begin
            n_fail++; $display("FAIL wb_bus: got wd=%h be=%b wr=%0b req=%0b stall=%0b addr=%h want a5a5a5a5 0100 1 1 0 00000020",
                busWriteData, busByteEnable, busWrite, busRequest, stall, busAddress);
        end
        tick();
        busAck = 1'b0; transactionControl = NO_OP; #1;
        n_checks++;
        if (busRequest !== 1'b0 || readValid !== 1'b0 || readData !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wb_done: got req=%0b rv=%0b rd=%h want 0 0 deadbeef", busRequest, readValid, readData);
        end
    endtask

    task automatic test_lanes();
        controlBus   cmds [3] = '{WRITE_BYTE0, WRITE_BYTE3, WRITE_WORD0};
        logic [3:0]  exp_be [3] = '{4'b0001, 4'b1000, 4'b0011};
        logic [31:0] exp_wd [3] = '{32'hC3C3C3C3, 32'hC3C3C3C3, 32'h54C354C3};
        for (int i = 0; i < 3; i++) begin
            transactionControl = cmds[i]; writeData = 32'h987654C3;
            tick();
            busAck = 1'b1; #1;
            n_checks++;
            if (busByteEnable !== exp_be[i] || busWriteData !== exp_wd[i] || busWrite !== 1'b1) begin
                n_fail++; $display("FAIL lanes[%0d]: got be=%b wd=%h wr=%0b want %b %h 1",
                    i, busByteEnable, busWriteData, busWrite, exp_be[i], exp_wd[i]);
            end
            tick();
            busAck = 1'b0; transactionControl = NO_OP;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        transactionControl = WRITE_WORD1; writeData = 32'h00001234;
        tick();
        busAck = 1'b1; #1;
        n_checks++;
        if (busByteEnable !== 4'b1100 || busWriteData !== 32'h12341234 || busRequest !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: got be=%b wd=%h req=%0b want 1100 12341234 1", busByteEnable, busWriteData, busRequest);
        end
        tick();
        busAck = 1'b0; transactionControl = WRITE_DWORD; writeData = 32'hCAFEF00D; #1;
        n_checks++;
        if (busRequest !== 1'b0 || stall !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gap: got req=%0b stall=%0b want 0 1", busRequest, stall);
        end
        tick();
        n_checks++;
        if (busRequest !== 1'b1 || busByteEnable !== 4'b1111 || busWriteData !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL b2b_second: got req=%0b be=%b wd=%h want 1 1111 cafef00d", busRequest, busByteEnable, busWriteData);
        end
        busAck = 1'b1;
        tick();
        busAck = 1'b0; transactionControl = NO_OP; #1;
        n_checks++;
        if (busRequest !== 1'b0) begin n_fail++; $display("FAIL b2b_end_req: got %0b want 0", busRequest); end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        transactionControl = READ; address = 32'h20;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (busRequest === 1'b1 && busError === 1'b0) req_cycles++;
            tick();
        end
        n_checks++;
        if (req_cycles != 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
        n_checks++;
        if (busError !== 1'b1 || busRequest !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL to_error: got err=%0b req=%0b stall=%0b want 1 0 0", busError, busRequest, stall);
        end
        transactionControl = NO_OP;
        tick();
        n_checks++;
        if (busError !== 1'b0 || readValid !== 1'b0 || readData !== 32'hDEADBEEF || busRequest !== 1'b0) begin
            n_fail++; $display("FAIL to_recover: got err=%0b rv=%0b rd=%h req=%0b want 0 0 deadbeef 0",
                busError, readValid, readData, busRequest);
        end
    endtask

    task automatic test_reset_mid();
        transactionControl = WRITE_DWORD; address = 32'h40; writeData = 32'h55AA33CC;
        tick(); tick();
        n_checks++;
        if (busRequest !== 1'b1) begin n_fail++; $display("FAIL rm_pre_req: got %0b want 1", busRequest); end
        reset = 1'b1; transactionControl = NO_OP;
        tick();
        n_checks++;
        if ({busRequest, stall, busWrite, busByteEnable, busError, readValid} !== 9'b0
            || {busAddress, busWriteData, readData} !== 96'b0) begin
            n_fail++; $display("FAIL rm_cleared: got req=%0b stall=%0b wr=%0b be=%b addr=%h wd=%h rd=%h want all 0",
                busRequest, stall, busWrite, busByteEnable, busAddress, busWriteData, readData);
        end
        reset = 1'b0; busAck = 1'b1; busReadData = 32'h01234567;
        tick();
        busAck = 1'b0; #1;
        n_checks++;
        if (readValid !== 1'b0 || readData !== 32'h0 || busRequest !== 1'b0 || busError !== 1'b0) begin
            n_fail++; $display("FAIL rm_late_ack: got rv=%0b rd=%h req=%0b err=%0b want 0 0 0 0", readValid, readData, busRequest, busError);
        end
    endtask

    task automatic test_idle_ack();
        transactionControl = NO_OP; busAck = 1'b1; busReadData = 32'hFFFF0000;
        tick();
        busAck = 1'b0;
        tick();
        n_checks++;
        if (readValid !== 1'b0 || readData !== 32'h0 || busRequest !== 1'b0) begin
            n_fail++; $display("FAIL idle_ack: got rv=%0b rd=%h req=%0b want 0 0 0", readValid, readData, busRequest);
        end
        transactionControl = controlBus'(4'hF); #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL unknown_cmd_stall: got %0b want 0", stall); end
        tick();
        n_checks++;
        if (busRequest !== 1'b0) begin n_fail++; $display("FAIL unknown_cmd_req: got %0b want 0", busRequest); end
        transactionControl = NO_OP;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_byte();
        test_lanes();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_idle_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
